// File: rtl/rob_pkg.sv
// rob_pkg: entry type carried on the execute-to-ROB result ports
package rob_pkg;
  typedef struct packed {
    logic [31:0] result_lo;
    logic [4:0]  dest_reg;
    logic        dest_reg_valid;
  } rob_entry_t;
endpackage

// File: rtl/rob_core.sv
// rob_core: reorder buffer with in-order allocation/retirement and two out-of-order result write ports
module rob_core
  import rob_pkg::*;
#(
  parameter int ROB_DEPTHLOG2 = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     alloc_req,
  output logic                     alloc_ready,
  output logic [ROB_DEPTHLOG2-1:0] alloc_slot,
  input  logic                     wr0_valid,
  input  logic [ROB_DEPTHLOG2-1:0] wr0_idx,
  input  rob_entry_t               wr0_data,
  input  logic                     wr1_valid,
  input  logic [ROB_DEPTHLOG2-1:0] wr1_idx,
  input  rob_entry_t               wr1_data,
  input  logic                     retire_stall,
  input  logic                     flush,
  output logic                     rf_wr_en,
  output logic [4:0]               rf_wr_reg,
  output logic [31:0]              rf_wr_data,
  output logic                     retire_pulse,
  output logic [ROB_DEPTHLOG2:0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     wr_err
);
  localparam int DEPTH = 1 << ROB_DEPTHLOG2;
  logic [ROB_DEPTHLOG2-1:0] head, tail;
  logic [DEPTH-1:0] alloc_q, done_q, alloc_oh, retire_oh, wr0_oh, wr1_oh;
  logic alloc_fire, retire_fire, wr0_ok, wr1_ok;
  rob_entry_t mem [DEPTH];
  rob_entry_t head_entry;
  assign full        = count == (ROB_DEPTHLOG2+1)'(DEPTH);
  assign empty       = count == '0;
  assign alloc_ready = ~full;
  assign alloc_slot  = tail;
  assign head_entry  = mem[head];
  assign alloc_fire  = alloc_req & alloc_ready & ~flush;
  assign retire_fire = ~empty & done_q[head] & ~retire_stall & ~flush;
  // the tail slot is never allocated while not full, so same-cycle alloc+write drops naturally
  assign wr0_ok = ~flush & wr0_valid & alloc_q[wr0_idx] & ~done_q[wr0_idx];
  assign wr1_ok = ~flush & wr1_valid & alloc_q[wr1_idx] & ~done_q[wr1_idx] & ~(wr0_valid & wr0_idx == wr1_idx);
  assign alloc_oh  = DEPTH'(alloc_fire) << tail;
  assign retire_oh = DEPTH'(retire_fire) << head;
  assign wr0_oh    = DEPTH'(wr0_ok) << wr0_idx;
  assign wr1_oh    = DEPTH'(wr1_ok) << wr1_idx;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      alloc_q      <= '0;
      done_q       <= '0;
      wr_err       <= 1'b0;
      retire_pulse <= 1'b0;
      rf_wr_en     <= 1'b0;
      rf_wr_reg    <= '0;
      rf_wr_data   <= '0;
    end else begin
      head         <= flush ? '0 : head + ROB_DEPTHLOG2'(retire_fire);
      tail         <= flush ? '0 : tail + ROB_DEPTHLOG2'(alloc_fire);
      count        <= flush ? '0 : count + (ROB_DEPTHLOG2+1)'(alloc_fire) - (ROB_DEPTHLOG2+1)'(retire_fire);
      alloc_q      <= flush ? '0 : (alloc_q | alloc_oh) & ~retire_oh;
      done_q       <= flush ? '0 : (done_q | wr0_oh | wr1_oh) & ~alloc_oh & ~retire_oh;
      wr_err       <= wr_err | (~flush & ((wr0_valid & ~wr0_ok) | (wr1_valid & ~wr1_ok)));
      retire_pulse <= retire_fire;
      rf_wr_en     <= retire_fire & head_entry.dest_reg_valid & |head_entry.dest_reg;
      rf_wr_reg    <= retire_fire ? head_entry.dest_reg : rf_wr_reg;
      rf_wr_data   <= retire_fire ? head_entry.result_lo : rf_wr_data;
    end
  end
  always_ff @(posedge clock) begin
    if (wr0_ok) mem[wr0_idx] <= wr0_data;
    if (wr1_ok) mem[wr1_idx] <= wr1_data;
  end
endmodule

// File: tb/tb_rob_core.sv
// tb_rob_core: directed scenarios plus randomized traffic against a program-order queue model
module tb_rob_core;
  import rob_pkg::*;
  localparam int DEPTH = 16;
  logic clock = 0, reset_n = 0;
  logic alloc_req = 0, alloc_ready, wr0_valid = 0, wr1_valid = 0, retire_stall = 0, flush = 0;
  logic [3:0] alloc_slot, wr0_idx = 0, wr1_idx = 0;
  rob_entry_t wr0_data = '0, wr1_data = '0;
  logic rf_wr_en, retire_pulse, empty, full, wr_err;
  logic [4:0] rf_wr_reg, count;
  logic [31:0] rf_wr_data;
  always #5 clock = ~clock;

  rob_core #(.ROB_DEPTHLOG2(4)) dut (
    .clock(clock), .reset_n(reset_n), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_slot(alloc_slot), .wr0_valid(wr0_valid), .wr0_idx(wr0_idx), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_idx(wr1_idx), .wr1_data(wr1_data), .retire_stall(retire_stall),
    .flush(flush), .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .retire_pulse(retire_pulse), .count(count), .empty(empty), .full(full), .wr_err(wr_err)
  );

  // model: entries in program order, each remembering its slot, completion and result
  typedef struct { int slot; bit done; rob_entry_t d; } ent_t;
  ent_t q[$];
  int tail_m;
  bit m_err, x_pulse, x_en;
  logic [4:0] x_reg;
  logic [31:0] x_data;
  int checks = 0, errors = 0;

  function automatic rob_entry_t mk(logic [31:0] d, logic [4:0] r, logic v);
    rob_entry_t e;
    e.result_lo = d; e.dest_reg = r; e.dest_reg_valid = v;
    return e;
  endfunction

  function automatic int find(int idx);
    foreach (q[i]) if (q[i].slot == idx) return i;
    return -1;
  endfunction

  task automatic model_write(int idx, rob_entry_t d);
    int k;
    ent_t t;
    k = find(idx);
    if (k >= 0 && !q[k].done) begin
      t = q[k]; t.done = 1; t.d = d; q[k] = t;
    end else m_err = 1;
  endtask

  task automatic step();
    bit ret, alloc_ok;
    ent_t e;
    ret = !flush && q.size() > 0 && q[0].done && !retire_stall;
    alloc_ok = alloc_req && q.size() < DEPTH && !flush;
    if (ret) e = q[0];
    if (!flush) begin
      if (wr0_valid) model_write(int'(wr0_idx), wr0_data);
      if (wr1_valid) model_write(int'(wr1_idx), wr1_data);
    end
    if (flush) begin
      q.delete(); tail_m = 0;
    end else begin
      if (ret) void'(q.pop_front());
      if (alloc_ok) begin
        q.push_back('{slot: tail_m, done: 0, d: '0});
        tail_m = (tail_m + 1) % DEPTH;
      end
    end
    x_pulse = ret;
    x_en = ret && e.d.dest_reg_valid && e.d.dest_reg != 0;
    if (ret) begin x_reg = e.d.dest_reg; x_data = e.d.result_lo; end
    @(posedge clock); #1;
    alloc_req = 0; wr0_valid = 0; wr1_valid = 0; flush = 0;
  endtask

  task automatic apply_reset();
    reset_n = 0; alloc_req = 0; wr0_valid = 0; wr1_valid = 0; retire_stall = 0; flush = 0;
    q.delete(); tail_m = 0; m_err = 0; x_pulse = 0; x_en = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
  endtask

  task automatic do_wr0(int idx, rob_entry_t d); wr0_valid = 1; wr0_idx = 4'(idx); wr0_data = d; endtask
  task automatic do_wr1(int idx, rob_entry_t d); wr1_valid = 1; wr1_idx = 4'(idx); wr1_data = d; endtask
  task automatic do_alloc(int n); repeat (n) begin alloc_req = 1; step(); end endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset empty: got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset full: got %b exp 0", full); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset alloc_ready: got %b exp 1", alloc_ready); end
    checks++; if (alloc_slot !== 4'd0) begin errors++; $display("FAIL reset alloc_slot: got %0d exp 0", alloc_slot); end
    checks++; if ({rf_wr_en, retire_pulse, wr_err} !== 3'b000) begin errors++; $display("FAIL reset strobes: got %b exp 000", {rf_wr_en, retire_pulse, wr_err}); end
  endtask

  task automatic test_basic_retire();
    do_alloc(1);
    do_wr0(0, mk(32'hDEADBEEF, 5'd3, 1'b1));
    step();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL basic early en: got %b exp 0", rf_wr_en); end
    step();
    checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL basic en: got %b exp 1", rf_wr_en); end
    checks++; if (rf_wr_reg !== 5'd3) begin errors++; $display("FAIL basic reg: got %0d exp 3", rf_wr_reg); end
    checks++; if (rf_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic data: got %h exp deadbeef", rf_wr_data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic empty: got %b exp 1", empty); end
  endtask

  task automatic test_out_of_order();
    logic [31:0] d [3];
    logic [4:0] r [3];
    apply_reset();
    do_alloc(3);
    for (int i = 0; i < 3; i++) begin d[i] = $urandom; r[i] = 5'(7 - i); end
    for (int i = 2; i >= 0; i--) begin
      do_wr0(i, mk(d[i], r[i], 1'b1));
      step();
      checks++; if (retire_pulse !== 1'b0) begin errors++; $display("FAIL ooo premature retire slot %0d: got %b exp 0", i, retire_pulse); end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({rf_wr_en, rf_wr_reg, rf_wr_data} !== {1'b1, r[i], d[i]}) begin errors++; $display("FAIL ooo retire %0d: got en=%b reg=%0d data=%h exp en=1 reg=%0d data=%h", i, rf_wr_en, rf_wr_reg, rf_wr_data, r[i], d[i]); end
    end
  endtask

  task automatic test_fill_wrap();
    apply_reset();
    do_alloc(DEPTH);
    checks++; if ({full, alloc_ready, count} !== {1'b1, 1'b0, 5'd16}) begin errors++; $display("FAIL fill: got full=%b ready=%b count=%0d exp 1 0 16", full, alloc_ready, count); end
    do_alloc(1);
    checks++; if (count !== 5'd16 || alloc_slot !== 4'd0) begin errors++; $display("FAIL 17th alloc: got count=%0d slot=%0d exp 16 0", count, alloc_slot); end
    do_wr0(0, mk(32'h1234, 5'd1, 1'b1));
    step(); step();
    checks++; if (count !== 5'd15 || alloc_slot !== 4'd0) begin errors++; $display("FAIL wrap retire: got count=%0d slot=%0d exp 15 0", count, alloc_slot); end
    do_alloc(1);
    checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL wrap alloc: got count=%0d full=%b exp 16 1", count, full); end
  endtask

  task automatic test_collision();
    apply_reset();
    do_alloc(2);
    do_wr0(0, mk(32'hA0, 5'd1, 1'b1));
    step();
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL collision pre err: got %b exp 0", wr_err); end
    do_wr0(1, mk(32'hB1, 5'd2, 1'b1));
    do_wr1(1, mk(32'hC2, 5'd3, 1'b1));
    step();
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL collision err: got %b exp 1", wr_err); end
    do_wr1(9, mk(32'hEE, 5'd4, 1'b1));
    step();
    checks++; if ({rf_wr_reg, rf_wr_data} !== {5'd2, 32'hB1}) begin errors++; $display("FAIL collision winner: got reg=%0d data=%h exp 2 b1", rf_wr_reg, rf_wr_data); end
    step();
    checks++; if (retire_pulse !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL unalloc write: got pulse=%b empty=%b exp 0 1", retire_pulse, empty); end
  endtask

  task automatic test_stall_nodest();
    apply_reset();
    do_alloc(3);
    do_wr0(0, mk(32'h11, 5'd4, 1'b0));
    do_wr1(1, mk(32'h22, 5'd0, 1'b1));
    step(); step();
    checks++; if ({retire_pulse, rf_wr_en} !== 2'b10) begin errors++; $display("FAIL no-dest: got pulse=%b en=%b exp 1 0", retire_pulse, rf_wr_en); end
    step();
    checks++; if ({retire_pulse, rf_wr_en} !== 2'b10) begin errors++; $display("FAIL reg0: got pulse=%b en=%b exp 1 0", retire_pulse, rf_wr_en); end
    retire_stall = 1;
    do_wr0(2, mk(32'h33, 5'd9, 1'b1));
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({retire_pulse, rf_wr_en} !== 2'b00) begin errors++; $display("FAIL stall cycle %0d: got pulse=%b en=%b exp 0 0", i, retire_pulse, rf_wr_en); end
    end
    retire_stall = 0;
    step();
    checks++; if ({retire_pulse, rf_wr_en, rf_wr_reg} !== {2'b11, 5'd9}) begin errors++; $display("FAIL stall release: got pulse=%b en=%b reg=%0d exp 1 1 9", retire_pulse, rf_wr_en, rf_wr_reg); end
  endtask

  task automatic test_flush();
    apply_reset();
    do_alloc(4);
    do_wr0(1, mk(32'h55, 5'd5, 1'b1));
    do_wr1(3, mk(32'h66, 5'd6, 1'b1));
    step();
    flush = 1;
    do_wr0(9, mk(32'h77, 5'd7, 1'b1));
    step();
    checks++; if ({count, empty, retire_pulse, alloc_slot} !== {5'd0, 1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL flush: got count=%0d empty=%b pulse=%b slot=%0d exp 0 1 0 0", count, empty, retire_pulse, alloc_slot); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL flush err: got %b exp 0", wr_err); end
    step();
    checks++; if (retire_pulse !== 1'b0) begin errors++; $display("FAIL post-flush retire: got %b exp 0", retire_pulse); end
  endtask

  task automatic test_random();
    int pend[$];
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(q[i].slot);
      alloc_req = ($urandom_range(0, 9) < 6);
      retire_stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1)
        do_wr0((pend.size() > 0 && $urandom_range(0, 19) != 0) ? pend[$urandom_range(0, pend.size() - 1)] : $urandom_range(0, 15), mk($urandom, 5'($urandom), 1'($urandom)));
      if ($urandom_range(0, 2) == 0)
        do_wr1((pend.size() > 0 && $urandom_range(0, 19) != 0) ? pend[$urandom_range(0, pend.size() - 1)] : $urandom_range(0, 15), mk($urandom, 5'($urandom), 1'($urandom)));
      step();
      checks++; if ({retire_pulse, rf_wr_en} !== {x_pulse, x_en}) begin errors++; $display("FAIL rnd %0d retire: got pulse=%b en=%b exp %b %b", n, retire_pulse, rf_wr_en, x_pulse, x_en); end
      if (x_en) begin
        checks++; if ({rf_wr_reg, rf_wr_data} !== {x_reg, x_data}) begin errors++; $display("FAIL rnd %0d rf: got reg=%0d data=%h exp %0d %h", n, rf_wr_reg, rf_wr_data, x_reg, x_data); end
      end
      checks++; if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || alloc_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL rnd %0d occupancy: got count=%0d empty=%b full=%b ready=%b exp count=%0d", n, count, empty, full, alloc_ready, q.size()); end
      checks++; if (alloc_slot !== 4'(tail_m) || wr_err !== m_err) begin errors++; $display("FAIL rnd %0d slot/err: got slot=%0d err=%b exp %0d %b", n, alloc_slot, wr_err, tail_m, m_err); end
    end
    retire_stall = 0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_alloc(2);
    do_wr0(0, mk(32'hCAFE, 5'd2, 1'b1));
    do_wr1(7, mk(32'hBAD, 5'd3, 1'b1));
    step();
    do_wr0(1, mk(32'hF00D, 5'd8, 1'b1));
    step();
    checks++; if ({retire_pulse, rf_wr_en, wr_err} !== 3'b111) begin errors++; $display("FAIL pre-reset: got pulse=%b en=%b err=%b exp 1 1 1", retire_pulse, rf_wr_en, wr_err); end
    #2 reset_n = 0;
    #1;
    checks++; if ({retire_pulse, rf_wr_en, wr_err, rf_wr_reg, rf_wr_data} !== '0) begin errors++; $display("FAIL async reset rf: got pulse=%b en=%b err=%b reg=%0d data=%h exp all 0", retire_pulse, rf_wr_en, wr_err, rf_wr_reg, rf_wr_data); end
    checks++; if ({count, empty, full, alloc_ready, alloc_slot} !== {5'd0, 1'b1, 1'b0, 1'b1, 4'd0}) begin errors++; $display("FAIL async reset occupancy: got count=%0d empty=%b full=%b ready=%b slot=%0d", count, empty, full, alloc_ready, alloc_slot); end
    apply_reset();
    step();
    checks++; if ({retire_pulse, count} !== 6'd0) begin errors++; $display("FAIL after reset idle: got pulse=%b count=%0d exp 0 0", retire_pulse, count); end
  endtask

  initial begin
    test_reset();
    test_basic_retire();
    test_out_of_order();
    test_fill_wrap();
    test_collision();
    test_stall_nodest();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
